polygon_vertex_buffer: RTL and testbench
========================================

// Module: polygon_vertex_buffer
// PURPOSE
//  Writer side of the polygon vertex interface consumed by in_polygon (xs/ys/num_sides).
//  Accepts a valid/ready vertex stream from the game/physics logic into a shadow bank.
//  Commits a completed polygon to the active bank only on a frame-start pulse, so the
//  pixel-path point-in-polygon test never sees a half-written polygon mid-frame.
// PARAMETERS
//  MAX_SIDES    4   capacity of each bank in vertices (>=3)
//  COORD_WIDTH  32  signed vertex coordinate width, pixels
// PORTS
//  clk_in           in   1                pixel clock; the only clock
//  rst_in           in   1                reset, asynchronous, active-low
//  vertex_x_in      in   COORD_WIDTH      signed vertex x
//  vertex_y_in      in   COORD_WIDTH      signed vertex y
//  vertex_valid_in  in   1                vertex presented
//  vertex_last_in   in   1                final vertex of this polygon
//  vertex_ready_out out  1                buffer can accept a vertex this cycle
//  frame_start_in   in   1                1-cycle pulse at hcount=0,vcount=0
//  xs_out           out  MAX_SIDES*COORD  active vertex x array, signed, to in_polygon
//  ys_out           out  MAX_SIDES*COORD  active vertex y array, signed
//  num_sides_out    out  $clog2(MAX_SIDES)+1  active vertex count, 0 or 3..MAX_SIDES
//  pending_out      out  1                complete polygon waiting for commit
//  overflow_err_out out  1                1-cycle pulse: vertex dropped, bank full
//  short_err_out    out  1                1-cycle pulse: polygon <3 vertices discarded
// BEHAVIOUR
//  Reset (async assert): xs/ys/shadow=0, num_sides=0, count=0, all outputs 0, state COLLECT.
//  vertex_ready_out is registered; first 1 on the first clk edge after rst_in deasserts.
//  Transfer = vertex_valid_in & vertex_ready_out on a rising edge.
//  State COLLECT (ready=1):
//   - transfer, !last, count<MAX_SIDES: shadow[count]<=vertex; count++.
//   - transfer, last: write shadow[count]; n=count+1. If n>=3 -> PENDING, pend_n=n;
//     else short_err pulse, count<=0, stay COLLECT. Active bank untouched.
//   - transfer when count==MAX_SIDES: vertex dropped, overflow_err pulse; if !last ->
//     DRAIN, if last -> count<=0, stay COLLECT. Active bank untouched.
//   - frame_start_in in COLLECT: no effect; a partial polygon survives across frames.
//  State DRAIN (ready=1): discard all transfers, no further err pulses; on last ->
//     count<=0, COLLECT.
//  State PENDING (ready=0, pending_out=1): on frame_start_in: active[i]<=shadow[i] for
//     i<pend_n, active[i]<=0 for i>=pend_n, num_sides<=pend_n, count<=0 -> COLLECT.
//  Latency: xs/ys/num_sides change on the edge sampling frame_start_in; visible the
//     following cycle (pixel 1 of line 0). All update in the same cycle, atomically.
//  Simultaneous last-transfer and frame_start_in in COLLECT: polygon enters PENDING,
//     commits on the NEXT frame_start_in, never the current one.
//  Ready drops the cycle after the last transfer (registered); no transfer is lost.
//  Reset mid-collect or mid-pending: shadow and active both cleared, num_sides=0.
//  Coordinates stored verbatim, no clipping or sign extension beyond COORD_WIDTH.
// STRUCTURE
//  polygon_pkg: MAX_SIDES, COORD_WIDTH defaults, coord_t (logic signed [COORD_WIDTH-1:0]),
//    vbuf_state_t enum {COLLECT, DRAIN, PENDING}.
//  One sub-module, vertex_bank: shadow/active register pair, write port and commit-with-
//    zero-fill; top level holds the FSM, counter and error pulses.
// TESTING
//  Square (100,100),(200,100),(200,200),(100,200), last on 4th; frame_start -> xs={100,200,
//    200,100}, ys={100,100,200,200}, num_sides=4 one cycle later; pending 1 -> 0.
//  Triangle (10,10),(50,10),(30,-40) after the square, commit -> num_sides=3, xs[3]=ys[3]=0,
//    ys[2]=-40; before that frame_start, outputs still hold the square.
//  Last vertex and frame_start_in on same edge -> no change that frame; next frame_start
//    commits; ready=0 throughout PENDING with valid held high, no vertex accepted.
//  MAX_SIDES=4, stream 6 vertices (last on 6th) -> one overflow_err pulse on 5th, active
//    unchanged, ready=1, next 3-vertex polygon commits normally.
//  Two-vertex polygon -> short_err pulse, pending stays 0, frame_start leaves outputs as-is.
//  Assert rst_in low mid-collect after 2 vertices -> all outputs 0 immediately, ready=0
//    until first edge after release; fresh 4-vertex polygon commits correctly.

Source files
------------

// File: rtl/polygon_vertex_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : polygon_pkg
// Description : Shared defaults, coordinate type and FSM states for the
//               polygon vertex buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package polygon_pkg;

  localparam int DEF_MAX_SIDES   = 4;
  localparam int DEF_COORD_WIDTH = 32;

  typedef logic signed [DEF_COORD_WIDTH-1:0] coord_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    PENDING = 2'd2
  } vbuf_state_t;

endpackage
`default_nettype wire

// File: rtl/polygon_vertex_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : polygon_vertex_buffer_if
// Description : Vertex stream, frame-start and active-polygon bundle between
//               the game logic, the vertex buffer and in_polygon.
// Revision    : 1.0 - initial release
// ============================================================================
interface polygon_vertex_buffer_if #(
  parameter int MAX_SIDES   = polygon_pkg::DEF_MAX_SIDES,
  parameter int COORD_WIDTH = polygon_pkg::DEF_COORD_WIDTH
);
  localparam int NUM_W = $clog2(MAX_SIDES) + 1;

  logic signed [COORD_WIDTH-1:0]     vertex_x_in;
  logic signed [COORD_WIDTH-1:0]     vertex_y_in;
  logic                              vertex_valid_in;
  logic                              vertex_last_in;
  logic                              vertex_ready_out;
  logic                              frame_start_in;
  logic [MAX_SIDES*COORD_WIDTH-1:0]  xs_out;
  logic [MAX_SIDES*COORD_WIDTH-1:0]  ys_out;
  logic [NUM_W-1:0]                  num_sides_out;
  logic                              pending_out;
  logic                              overflow_err_out;
  logic                              short_err_out;

  modport master (
    output vertex_x_in, vertex_y_in, vertex_valid_in, vertex_last_in, frame_start_in,
    input  vertex_ready_out, xs_out, ys_out, num_sides_out, pending_out,
           overflow_err_out, short_err_out
  );

  modport slave (
    input  vertex_x_in, vertex_y_in, vertex_valid_in, vertex_last_in, frame_start_in,
    output vertex_ready_out, xs_out, ys_out, num_sides_out, pending_out,
           overflow_err_out, short_err_out
  );

endinterface
`default_nettype wire

// File: rtl/polygon_vertex_buffer_bank.sv
`default_nettype none
// ============================================================================
// Module      : vertex_bank
// Description : Shadow/active vertex register pair; shadow written one slot at
//               a time, copied to active with zero-fill on commit.
// Revision    : 1.0 - initial release
// ============================================================================
module vertex_bank #(
  parameter int MAX_SIDES   = polygon_pkg::DEF_MAX_SIDES,
  parameter int COORD_WIDTH = polygon_pkg::DEF_COORD_WIDTH,
  parameter int CNT_W       = $clog2(MAX_SIDES) + 1
) (
  input  wire logic                             clk,
  input  wire logic                             rst_n,
  input  wire logic                             i_wr_en,
  input  wire logic [CNT_W-1:0]                 i_wr_idx,
  input  wire logic signed [COORD_WIDTH-1:0]    i_wr_x,
  input  wire logic signed [COORD_WIDTH-1:0]    i_wr_y,
  input  wire logic                             i_commit,
  input  wire logic [CNT_W-1:0]                 i_commit_n,
  output logic [MAX_SIDES*COORD_WIDTH-1:0]      o_xs,
  output logic [MAX_SIDES*COORD_WIDTH-1:0]      o_ys,
  output logic [CNT_W-1:0]                      o_num_sides
);

  generate
    for (genvar gi = 0; gi < MAX_SIDES; gi++) begin : g_slot
      logic signed [COORD_WIDTH-1:0] r_shadow_x;
      logic signed [COORD_WIDTH-1:0] r_shadow_y;
      logic signed [COORD_WIDTH-1:0] r_active_x;
      logic signed [COORD_WIDTH-1:0] r_active_y;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shadow_x <= '0;
          r_shadow_y <= '0;
          r_active_x <= '0;
          r_active_y <= '0;
        end else begin
          if (i_wr_en && (i_wr_idx == CNT_W'(gi))) begin
            r_shadow_x <= i_wr_x;
            r_shadow_y <= i_wr_y;
          end
          // Slots beyond the committed count are zeroed so stale vertices never leak
          if (i_commit) begin
            if (CNT_W'(gi) < i_commit_n) begin
              r_active_x <= r_shadow_x;
              r_active_y <= r_shadow_y;
            end else begin
              r_active_x <= '0;
              r_active_y <= '0;
            end
          end
        end
      end

      assign o_xs[gi*COORD_WIDTH +: COORD_WIDTH] = r_active_x;
      assign o_ys[gi*COORD_WIDTH +: COORD_WIDTH] = r_active_y;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_num_sides <= '0;
    end else if (i_commit) begin
      o_num_sides <= i_commit_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/polygon_vertex_buffer.sv
`default_nettype none
// ============================================================================
// Module      : polygon_vertex_buffer
// Description : Collects a vertex stream into a shadow bank and commits a
//               complete polygon to the active bank on frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module polygon_vertex_buffer #(
  parameter int MAX_SIDES   = polygon_pkg::DEF_MAX_SIDES,
  parameter int COORD_WIDTH = polygon_pkg::DEF_COORD_WIDTH
) (
  input  wire logic                clk_in,
  input  wire logic                rst_in,
  polygon_vertex_buffer_if.slave   bus
);
  import polygon_pkg::*;

  localparam int              CNT_W  = $clog2(MAX_SIDES) + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(MAX_SIDES);
  localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(3);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  vbuf_state_t      r_state;
  vbuf_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_count_inc;
  logic [CNT_W-1:0] r_pend_n;
  logic [CNT_W-1:0] w_pend_n_nxt;
  logic             r_ready;
  logic             r_overflow;
  logic             r_short;
  logic             w_overflow;
  logic             w_short;
  logic             w_wr_en;
  logic             w_commit;
  logic             w_xfer;

  logic [MAX_SIDES*COORD_WIDTH-1:0] w_xs;
  logic [MAX_SIDES*COORD_WIDTH-1:0] w_ys;
  logic [CNT_W-1:0]                 w_num_sides;

  assign w_xfer      = bus.vertex_valid_in & r_ready;
  assign w_count_inc = r_count + C_ONE;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= COLLECT;
      r_count    <= '0;
      r_pend_n   <= '0;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
      r_short    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_pend_n   <= w_pend_n_nxt;
      r_ready    <= (w_state_nxt != PENDING);
      r_overflow <= w_overflow;
      r_short    <= w_short;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_pend_n_nxt = r_pend_n;
    w_wr_en      = 1'b0;
    w_commit     = 1'b0;
    w_overflow   = 1'b0;
    w_short      = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_xfer) begin
          if (r_count == C_FULL) begin
            w_overflow = 1'b1;
            if (bus.vertex_last_in) w_count_nxt = '0;
            else                    w_state_nxt = DRAIN;
          end else begin
            w_wr_en = 1'b1;
            if (bus.vertex_last_in) begin
              if (w_count_inc >= C_MIN) begin
                w_state_nxt  = PENDING;
                w_pend_n_nxt = w_count_inc;
              end else begin
                w_short     = 1'b1;
                w_count_nxt = '0;
              end
            end else begin
              w_count_nxt = w_count_inc;
            end
          end
        end
      end
      DRAIN: begin
        // Remainder of an oversized polygon is swallowed silently
        if (w_xfer && bus.vertex_last_in) begin
          w_count_nxt = '0;
          w_state_nxt = COLLECT;
        end
      end
      PENDING: begin
        if (bus.frame_start_in) begin
          w_commit    = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  vertex_bank #(
    .MAX_SIDES   (MAX_SIDES),
    .COORD_WIDTH (COORD_WIDTH),
    .CNT_W       (CNT_W)
  ) u_bank (
    .clk         (clk_in),
    .rst_n       (rst_in),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (r_count),
    .i_wr_x      (bus.vertex_x_in),
    .i_wr_y      (bus.vertex_y_in),
    .i_commit    (w_commit),
    .i_commit_n  (r_pend_n),
    .o_xs        (w_xs),
    .o_ys        (w_ys),
    .o_num_sides (w_num_sides)
  );

  assign bus.xs_out           = w_xs;
  assign bus.ys_out           = w_ys;
  assign bus.num_sides_out    = w_num_sides;
  assign bus.vertex_ready_out = r_ready;
  assign bus.pending_out      = (r_state == PENDING);
  assign bus.overflow_err_out = r_overflow;
  assign bus.short_err_out    = r_short;

endmodule
`default_nettype wire

// File: tb/tb_polygon_vertex_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_polygon_vertex_buffer
// Description : Directed plus random stimulus against a queue-based polygon
//               model, with a scoreboard monitor comparing every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_polygon_vertex_buffer;

  localparam int MS = 4;
  localparam int CW = 32;
  localparam int NW = $clog2(MS) + 1;

  typedef enum int { K_COMMIT, K_OVF, K_SHORT } kind_t;
  typedef struct {
    kind_t            kind;
    int               due;
    logic [MS*CW-1:0] xs;
    logic [MS*CW-1:0] ys;
    logic [NW-1:0]    num;
  } ev_t;

  logic clk    = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk = ~clk;

  polygon_vertex_buffer_if #(.MAX_SIDES(MS), .COORD_WIDTH(CW)) bus ();

  polygon_vertex_buffer #(.MAX_SIDES(MS), .COORD_WIDTH(CW)) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: polygon under construction as plain queues
  ev_t                  evq[$];
  logic signed [CW-1:0] sx[$];
  logic signed [CW-1:0] sy[$];
  int                   m_mode;   // 0 collecting, 1 discarding oversize, 2 awaiting frame
  bit                   m_ready;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, got, exp);
    end
  endtask

  task automatic model_reset();
    sx.delete();
    sy.delete();
    m_mode  = 0;
    m_ready = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic signed [CW-1:0] x,
                            input logic signed [CW-1:0] y, input bit l, input bit fs);
    ev_t e;
    e.due = edge_cnt;
    e.xs  = '0;
    e.ys  = '0;
    e.num = '0;
    if (m_mode == 2) begin
      if (fs) begin
        e.kind = K_COMMIT;
        for (int i = 0; i < sx.size(); i++) begin
          e.xs[i*CW +: CW] = sx[i];
          e.ys[i*CW +: CW] = sy[i];
        end
        e.num = NW'(sx.size());
        evq.push_back(e);
        sx.delete();
        sy.delete();
        m_mode = 0;
      end
    end else if (v && m_ready) begin
      if (m_mode == 1) begin
        if (l) begin
          sx.delete();
          sy.delete();
          m_mode = 0;
        end
      end else if (sx.size() == MS) begin
        e.kind = K_OVF;
        evq.push_back(e);
        if (l) begin
          sx.delete();
          sy.delete();
        end else begin
          m_mode = 1;
        end
      end else begin
        sx.push_back(x);
        sy.push_back(y);
        if (l) begin
          if (sx.size() >= 3) begin
            m_mode = 2;
          end else begin
            e.kind = K_SHORT;
            evq.push_back(e);
            sx.delete();
            sy.delete();
          end
        end
      end
    end
    m_ready = (m_mode != 2);
  endtask

  task automatic step(input bit v, input logic signed [CW-1:0] x, input logic signed [CW-1:0] y,
                      input bit l, input bit fs);
    bus.vertex_valid_in = v;
    bus.vertex_x_in     = x;
    bus.vertex_y_in     = y;
    bus.vertex_last_in  = l;
    bus.frame_start_in  = fs;
    @(posedge clk);
    #1;
    if (rst_in) model_edge(v, x, y, l, fs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Monitor / scoreboard
  logic [MS*CW-1:0] exp_xs;
  logic [MS*CW-1:0] exp_ys;
  logic [NW-1:0]    exp_num;
  bit               exp_ovf;
  bit               exp_short;

  initial begin
    ev_t e;
    exp_xs  = '0;
    exp_ys  = '0;
    exp_num = '0;
    forever begin
      @(negedge clk);
      exp_ovf   = 1'b0;
      exp_short = 1'b0;
      if (!rst_in) begin
        exp_xs  = '0;
        exp_ys  = '0;
        exp_num = '0;
        evq.delete();
      end
      while (evq.size() > 0 && evq[0].due <= edge_cnt) begin
        e = evq.pop_front();
        case (e.kind)
          K_COMMIT: begin
            exp_xs  = e.xs;
            exp_ys  = e.ys;
            exp_num = e.num;
          end
          K_OVF:   exp_ovf   = 1'b1;
          default: exp_short = 1'b1;
        endcase
      end
      check("xs_out",           bus.xs_out,           exp_xs);
      check("ys_out",           bus.ys_out,           exp_ys);
      check("num_sides_out",    bus.num_sides_out,    exp_num);
      check("overflow_err_out", bus.overflow_err_out, exp_ovf);
      check("short_err_out",    bus.short_err_out,    exp_short);
      check("vertex_ready_out", bus.vertex_ready_out, m_ready);
      check("pending_out",      bus.pending_out,      (m_mode == 2) && rst_in);
    end
  end

  // Stimulus
  initial begin
    bus.vertex_valid_in = 1'b0;
    bus.vertex_x_in     = '0;
    bus.vertex_y_in     = '0;
    bus.vertex_last_in  = 1'b0;
    bus.frame_start_in  = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    rst_in = 1'b1;
    idle(1);

    // Square, then valid held high while pending, then commit
    step(1, 100, 100, 0, 0);
    step(1, 200, 100, 0, 0);
    step(1, 200, 200, 0, 0);
    step(1, 100, 200, 1, 0);
    repeat (3) step(1, -7, -7, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(2);

    // Triangle whose last vertex coincides with frame start
    step(1, 10, 10, 0, 0);
    step(1, 50, 10, 0, 0);
    step(1, 30, -40, 1, 1);
    repeat (3) step(1, 5, 5, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(2);

    // Six-vertex stream overflows a four-slot bank
    for (int i = 0; i < 6; i++) step(1, i * 3, i * 7, (i == 5), 0);
    step(1, 1, 2, 0, 0);
    step(1, 3, 4, 0, 0);
    step(1, 5, 6, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(2);

    // Two-vertex polygon is discarded
    step(1, 8, 8, 0, 0);
    step(1, 9, 9, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 1);
    idle(2);

    // Reset in the middle of collecting
    step(1, 11, 11, 0, 0);
    step(1, 12, 12, 0, 0);
    rst_in = 1'b0;
    model_reset();
    #1;
    check("rst_xs",      bus.xs_out,           '0);
    check("rst_ys",      bus.ys_out,           '0);
    check("rst_num",     bus.num_sides_out,    '0);
    check("rst_ready",   bus.vertex_ready_out, 1'b0);
    check("rst_pending", bus.pending_out,      1'b0);
    repeat (2) step(1, 0, 0, 0, 0);
    rst_in = 1'b1;
    step(1, 77, 77, 0, 0);
    step(1, -1, -2, 0, 0);
    step(1, 300, -400, 0, 0);
    step(1, 32'h7fff_ffff, 32'h8000_0000, 0, 0);
    step(1, 0, 9, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 1)), $urandom, $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
